// File: rtl/amm_pkg.sv
// Shared types and helpers for the Avalon-MM SDRAM slave model.
// Holds the window base, error pattern, read-pipe entry and address decode.
package amm_pkg;

    localparam logic [31:0] SDRAM_ADDR = 32'h0800_0000;
    localparam logic [31:0] ERR_DATA   = 32'hBAD0_BAD0;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } rd_entry_t;

    typedef struct packed {
        logic        legal;
        logic [31:0] index;
    } amm_idx_t;

    // Word index from a byte address; legal only for aligned in-window hits.
    function automatic amm_idx_t amm_word_index(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] depth
    );
        amm_idx_t    r;
        logic [31:0] off;
        off     = addr - base;
        r.index = off >> 2;
        r.legal = (addr >= base) && (addr[1:0] == 2'b00)
                  && ((off >> 2) < depth);
        return r;
    endfunction

endpackage

// File: rtl/amm_sdram_slave_model_if.sv
// Avalon-MM single-word bus between the custom master and the SDRAM model.
// The master drives requests; the slave drives backpressure and returns.
interface amm_sdram_slave_model_if #(
    parameter int ADDRESSWIDTH = 26,
    parameter int DATAWIDTH    = 32
);
    logic [ADDRESSWIDTH-1:0] slave_address;
    logic [DATAWIDTH-1:0]    slave_writedata;
    logic                    slave_write;
    logic                    slave_read;
    logic                    slave_waitrequest;
    logic [DATAWIDTH-1:0]    slave_readdata;
    logic                    slave_readdatavalid;

    modport master (
        output slave_address, slave_writedata,
        output slave_write, slave_read,
        input  slave_waitrequest, slave_readdata,
        input  slave_readdatavalid
    );

    modport slave (
        input  slave_address, slave_writedata,
        input  slave_write, slave_read,
        output slave_waitrequest, slave_readdata,
        output slave_readdatavalid
    );
endinterface

// File: rtl/amm_rd_pipe.sv
// Fixed-latency read return pipe with synchronous clear.
// Data only advances behind a valid bit, so the tail holds the last return.
module amm_rd_pipe
    import amm_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic      clk,
    input  logic      clr,
    input  rd_entry_t push_entry,
    output rd_entry_t head
);

    rd_entry_t stage [LATENCY];

    // Shift entries one stage per cycle; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0].valid <= push_entry.valid;
            if (push_entry.valid) begin
                stage[0].data <= push_entry.data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage[i].valid <= stage[i-1].valid;
                if (stage[i-1].valid) begin
                    stage[i].data <= stage[i-1].data;
                end
            end
        end
    end

    assign head = stage[LATENCY-1];

endmodule

// File: rtl/amm_sdram_slave_model.sv
// Avalon-MM slave backed by a word array at the SDRAM window base.
// Adds waitrequest stalls, a read-pending limit and illegal-access counting.
module amm_sdram_slave_model #(
    parameter int          ADDRESSWIDTH = 26,
    parameter int          DATAWIDTH    = 32,
    parameter logic [31:0] BASE_ADDR    = amm_pkg::SDRAM_ADDR,
    parameter int          DEPTH_WORDS  = 256,
    parameter int          READ_LATENCY = 2,
    parameter int          MAX_PENDING  = 2,
    parameter logic [31:0] ERR_DATA     = amm_pkg::ERR_DATA
) (
    input  logic                          clk,
    input  logic                          reset,
    amm_sdram_slave_model_if.slave        bus,
    input  logic [3:0]                    stall_period,
    output logic [15:0]                   err_count,
    output logic [3:0]                    pending
);
    import amm_pkg::*;

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_MASK = (ADDRESSWIDTH >= 32)
        ? 32'hFFFF_FFFF : ((32'd1 << ADDRESSWIDTH) - 32'd1);
    localparam logic [31:0] BASE_T = BASE_ADDR & ADDR_MASK;

    logic [DATAWIDTH-1:0] mem [DEPTH_WORDS];

    logic [31:0] addr32;
    amm_idx_t    wi;
    logic [IW-1:0] idx;
    logic        unused_idx_hi;
    logic [3:0]  stall_cnt;
    logic [3:0]  prev_period;
    logic        stall_now;
    logic        waitreq;
    logic        accept;
    logic        do_write;
    logic        do_read;
    logic        err_inc;
    rd_entry_t   push;
    rd_entry_t   head;

    assign addr32        = 32'(bus.slave_address);
    assign wi            = amm_word_index(addr32, BASE_T,
                                          32'(DEPTH_WORDS));
    assign idx           = wi.index[IW-1:0];
    assign unused_idx_hi = ^wi.index[31:IW];

    assign stall_now = (stall_period != 4'd0)
                       && (stall_cnt == stall_period);
    assign waitreq   = reset | stall_now
                       | (pending == 4'(MAX_PENDING));
    assign accept    = (bus.slave_read | bus.slave_write) & ~waitreq;
    assign do_write  = accept & bus.slave_write & wi.legal;
    assign do_read   = accept & bus.slave_read & ~bus.slave_write;
    // A combined read+write is one error, regardless of address.
    assign err_inc   = accept & ((bus.slave_read & bus.slave_write)
                                 | ~wi.legal);

    assign push.valid = do_read;
    assign push.data  = wi.legal ? mem[idx] : ERR_DATA;

    assign bus.slave_waitrequest   = waitreq;
    assign bus.slave_readdatavalid = head.valid;
    assign bus.slave_readdata      = head.data;

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= bus.slave_writedata;
        end
    end

    // Free-running stall counter, restarted whenever the period changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt   <= 4'd0;
            prev_period <= stall_period;
        end else if (stall_period != prev_period) begin
            stall_cnt   <= 4'd0;
            prev_period <= stall_period;
        end else if (stall_cnt == stall_period) begin
            stall_cnt <= 4'd0;
        end else begin
            stall_cnt <= stall_cnt + 4'd1;
        end
    end

    // Outstanding reads: up on accept, down on return.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 4'd0;
        end else begin
            pending <= pending + 4'(do_read) - 4'(head.valid);
        end
    end

    // Saturating illegal-access counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 16'd0;
        end else if (err_inc && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

    amm_rd_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk        (clk),
        .clr        (reset),
        .push_entry (push),
        .head       (head)
    );

endmodule
